// File: rtl/ram_lock_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ram_lock_pkg                                              |
// | Brief    : Op-word encode/decode helpers and lock FSM state type for |
// |            the shared-RAM lock arbiter.                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ram_lock_pkg;

  // Function tag of the shared-RAM unit
  localparam logic [3:0] FUNC_TAG_RAM = 4'b1100;

  // Upper nibble shared by every lock-control op word
  localparam logic [3:0] c_op_prefix = 4'hF;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  function automatic logic [15:0] start_word(input logic [3:0] tag, input logic [3:0] prty);
    return {c_op_prefix, tag, 4'h0, prty};
  endfunction

  function automatic logic [15:0] stop_word(input logic [3:0] tag);
    return {c_op_prefix, tag, 8'hFF};
  endfunction

  // A priority of zero is "no request", so it does not count as a start word
  function automatic logic is_start(input logic [15:0] word, input logic [3:0] tag);
    return (word[15:12] == c_op_prefix) && (word[11:8] == tag) &&
           (word[7:4] == 4'h0) && (word[3:0] != 4'h0);
  endfunction

  function automatic logic is_stop(input logic [15:0] word, input logic [3:0] tag);
    return word == stop_word(tag);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_lock_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ram_lock_if                                               |
// | Brief    : Node-side op words and arbiter-side outputs of the        |
// |            shared-RAM lock arbiter.                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface ram_lock_if #(
  parameter int N_NODES = 4
);
  logic [16*N_NODES-1:0] in_op_node;
  logic [15:0]           out_op;
  logic [N_NODES-1:0]    grant;
  logic [2:0]            owner;
  logic                  busy;
  logic                  timeout_evt;

  // Request side: drives op words, observes arbitration results
  modport master (
    output in_op_node,
    input  out_op, grant, owner, busy, timeout_evt
  );

  // Arbiter side
  modport slave (
    input  in_op_node,
    output out_op, grant, owner, busy, timeout_evt
  );
endinterface
`default_nettype wire

// File: rtl/ram_lock_arbiter_prio_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : prio_rr_picker                                            |
// | Brief    : Combinational max-priority picker with round-robin        |
// |            tie-break starting at rr_ptr.                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module prio_rr_picker #(
  parameter int N_NODES = 4
) (
  input  logic [N_NODES-1:0]      valid,
  input  logic [N_NODES-1:0][3:0] prio,
  input  logic [2:0]              rr_ptr,
  output logic [2:0]              winner,
  output logic                    any_valid
);

  logic [3:0] w_max;
  logic       w_found;

  assign any_valid = |valid;

  // Highest priority among the valid requesters
  always_comb begin
    w_max = 4'h0;
    for (int i = 0; i < N_NODES; i++) begin
      if (valid[i] && (prio[i] > w_max)) w_max = prio[i];
    end
  end

  // First requester at the maximum priority, scanning cyclically from rr_ptr
  always_comb begin
    winner  = 3'd0;
    w_found = 1'b0;
    for (int k = 0; k < N_NODES; k++) begin
      logic [3:0] idx;
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(N_NODES)) idx = idx - 4'(N_NODES);
      // Compare against each slot rather than indexing, so the index stays in range
      for (int j = 0; j < N_NODES; j++) begin
        if (!w_found && (idx == 4'(j)) && valid[j] && (prio[j] == w_max)) begin
          winner  = 3'(j);
          w_found = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_lock_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ram_lock_arbiter                                          |
// | Brief    : Shares a single-port RAM function unit between N nodes   |
// |            using start/stop op words, priority + round-robin        |
// |            arbitration, registered forwarding and a lock watchdog.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ram_lock_arbiter
  import ram_lock_pkg::*;
#(
  parameter int         N_NODES = 4,
  parameter logic [3:0] TAG     = FUNC_TAG_RAM,
  parameter int         TIMEOUT = 1024
) (
  input  logic         CLK,
  input  logic         RST,
  ram_lock_if.slave    bus
);

  localparam bit         c_wd_en   = (TIMEOUT != 0);
  // Last watchdog count before a forced release; unused when the watchdog is off
  localparam logic [15:0] c_wd_last = c_wd_en ? 16'(TIMEOUT - 1) : 16'h0000;
  localparam logic [3:0]  c_n_nodes = 4'(N_NODES);

  logic [N_NODES-1:0][15:0] w_word;
  logic [N_NODES-1:0]       w_valid;
  logic [N_NODES-1:0][3:0]  w_prio;
  logic [2:0]               w_winner;
  logic                     w_any_valid;
  logic [N_NODES-1:0]       w_winner_oh;
  logic [15:0]              w_own_word;
  logic [15:0]              w_winner_word;
  logic [3:0]               w_rr_inc;
  logic [2:0]               w_next_rr;

  lock_state_t        r_state;
  logic [15:0]        r_out_op;
  logic [N_NODES-1:0] r_grant;
  logic [2:0]         r_owner;
  logic               r_busy;
  logic               r_timeout_evt;
  logic [2:0]         r_rr_ptr;
  logic [15:0]        r_wd_cnt;

  generate
    for (genvar gi = 0; gi < N_NODES; gi++) begin : g_decode
      assign w_word[gi]  = bus.in_op_node[16*gi +: 16];
      assign w_valid[gi] = is_start(w_word[gi], TAG);
      assign w_prio[gi]  = w_word[gi][3:0];
    end
  endgenerate

  prio_rr_picker #(
    .N_NODES (N_NODES)
  ) u_picker (
    .valid     (w_valid),
    .prio      (w_prio),
    .rr_ptr    (r_rr_ptr),
    .winner    (w_winner),
    .any_valid (w_any_valid)
  );

  // Select the owner's and the winner's words and form the winner's one-hot grant
  always_comb begin
    w_own_word    = 16'h0000;
    w_winner_word = 16'h0000;
    w_winner_oh   = '0;
    for (int i = 0; i < N_NODES; i++) begin
      if (r_owner == 3'(i)) w_own_word = w_word[i];
      if (w_winner == 3'(i)) begin
        w_winner_word  = w_word[i];
        w_winner_oh[i] = 1'b1;
      end
    end
  end

  // Round-robin pointer moves to the node just after the winner
  always_comb begin
    w_rr_inc  = {1'b0, w_winner} + 4'd1;
    w_next_rr = (w_rr_inc == c_n_nodes) ? 3'd0 : w_rr_inc[2:0];
  end

  // Lock FSM with registered forwarding path and watchdog
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_out_op      <= 16'h0000;
      r_grant       <= '0;
      r_owner       <= 3'd0;
      r_busy        <= 1'b0;
      r_timeout_evt <= 1'b0;
      r_rr_ptr      <= 3'd0;
      r_wd_cnt      <= 16'h0000;
    end else begin
      r_timeout_evt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_state  <= LOCKED;
            r_out_op <= w_winner_word;
            r_grant  <= w_winner_oh;
            r_owner  <= w_winner;
            r_busy   <= 1'b1;
            r_rr_ptr <= w_next_rr;
            r_wd_cnt <= 16'h0000;
          end else begin
            r_out_op <= 16'h0000;
            r_grant  <= '0;
            r_owner  <= 3'd0;
            r_busy   <= 1'b0;
          end
        end
        LOCKED: begin
          if (is_stop(w_own_word, TAG)) begin
            // A real stop wins over a simultaneous watchdog expiry
            r_state  <= IDLE;
            r_out_op <= w_own_word;
            r_grant  <= '0;
            r_owner  <= 3'd0;
            r_busy   <= 1'b0;
          end else if (c_wd_en && (r_wd_cnt == c_wd_last)) begin
            // Synthesised stop frees the RAM unit's internal lock
            r_state       <= IDLE;
            r_out_op      <= stop_word(TAG);
            r_grant       <= '0;
            r_owner       <= 3'd0;
            r_busy        <= 1'b0;
            r_timeout_evt <= 1'b1;
          end else begin
            r_out_op <= w_own_word;
            r_wd_cnt <= r_wd_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_op      = r_out_op;
  assign bus.grant       = r_grant;
  assign bus.owner       = r_owner;
  assign bus.busy        = r_busy;
  assign bus.timeout_evt = r_timeout_evt;

endmodule
`default_nettype wire

// File: tb/tb_ram_lock_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ram_lock_arbiter                                       |
// | Brief    : Scoreboard bench for ram_lock_arbiter: directed scenarios |
// |            followed by randomized traffic against a reference model.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ram_lock_arbiter;

  localparam int N  = 4;
  localparam int TO = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  ram_lock_if #(.N_NODES(N)) bus ();

  ram_lock_arbiter #(
    .N_NODES (N),
    .TAG     (4'b1100),
    .TIMEOUT (TO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] out_op;
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic        busy;
    logic        evt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_rr     = 0;
  int m_age    = 0;   // busy cycles already shown for the current lock

  function automatic bit ref_is_start(input logic [15:0] w);
    return (w[15:8] == 8'hFC) && (w[7:4] == 4'h0) && (w[3:0] != 4'h0);
  endfunction

  // Drive one cycle of inputs, predict the outputs after the next edge
  task automatic step(input bit rst, input logic [63:0] v);
    logic [15:0] w [N];
    exp_t e;
    int best, bp, p, idx;
    for (int i = 0; i < N; i++) w[i] = v[16*i +: 16];
    RST            = rst;
    bus.in_op_node = v;
    e = '0;
    if (rst) begin
      m_locked = 1'b0;
      m_owner  = 0;
      m_rr     = 0;
      m_age    = 0;
    end else if (!m_locked) begin
      best = -1;
      bp   = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        p   = ref_is_start(w[idx]) ? int'(w[idx][3:0]) : 0;
        if (p > bp) begin
          bp   = p;
          best = idx;
        end
      end
      if (best >= 0) begin
        m_locked = 1'b1;
        m_owner  = best;
        m_rr     = (best + 1) % N;
        m_age    = 1;
        e.out_op = w[best];
        e.grant  = 4'(1 << best);
        e.owner  = 3'(best);
        e.busy   = 1'b1;
      end
    end else begin
      if (w[m_owner] == 16'hFCFF) begin
        e.out_op = 16'hFCFF;
        m_locked = 1'b0;
      end else if (m_age == TO) begin
        e.out_op = 16'hFCFF;
        e.evt    = 1'b1;
        m_locked = 1'b0;
      end else begin
        e.out_op = w[m_owner];
        e.grant  = 4'(1 << m_owner);
        e.owner  = 3'(m_owner);
        e.busy   = 1'b1;
        m_age    = m_age + 1;
      end
    end
    sb.push_back(e);
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor: the DUT presents a result every cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_op", bus.out_op, e.out_op);
        chk("grant", 16'(bus.grant), 16'(e.grant));
        chk("owner", 16'(bus.owner), 16'(e.owner));
        chk("busy", 16'(bus.busy), 16'(e.busy));
        chk("timeout_evt", 16'(bus.timeout_evt), 16'(e.evt));
      end
    end
  end

  initial begin
    logic [63:0] v;
    bit          r;
    int          sel;
    bus.in_op_node = '0;

    // Reset
    step(1'b1, 64'h0);
    step(1'b1, 64'h0);

    // Unique winner: node2 (prio 9) beats node0 (prio 5)
    step(1'b0, {16'h0000, 16'hFC09, 16'h0000, 16'hFC05});
    step(1'b0, {16'h0000, 16'h1C11, 16'h0000, 16'hFC05});
    step(1'b0, {16'h0000, 16'hFCFF, 16'h0000, 16'h0000});
    step(1'b0, 64'h0);

    // Start word carrying a foreign tag is not a request
    step(1'b0, {16'h0000, 16'h0000, 16'h0000, 16'hFA05});
    step(1'b0, 64'h0);

    // Move rr_ptr to 2 via a node1 lock
    step(1'b0, {16'h0000, 16'h0000, 16'hFC01, 16'h0000});
    step(1'b0, {16'h0000, 16'h0000, 16'hFCFF, 16'h0000});
    step(1'b0, 64'h0);

    // Tie between node1 and node3: node3, then node1 on the repeat
    step(1'b0, {16'hFC07, 16'h0000, 16'hFC07, 16'h0000});
    step(1'b0, {16'hFCFF, 16'h0000, 16'h0000, 16'h0000});
    step(1'b0, 64'h0);
    step(1'b0, {16'hFC07, 16'h0000, 16'hFC07, 16'h0000});

    // Forwarding and isolation with node1 owning
    step(1'b0, {16'h0000, 16'h0000, 16'h1C2A, 16'hFCFF});
    step(1'b0, {16'h0000, 16'hFC0F, 16'hFC03, 16'h0000});

    // Release gap: owner stops while node0 waits
    step(1'b0, {16'h0000, 16'h0000, 16'hFCFF, 16'hFC03});
    step(1'b0, {16'h0000, 16'h0000, 16'h0000, 16'hFC03});
    step(1'b0, {16'h0000, 16'h0000, 16'h0000, 16'h5555});
    step(1'b0, {16'h0000, 16'h0000, 16'h0000, 16'hFCFF});
    step(1'b0, 64'h0);

    // Watchdog: node2 never stops
    step(1'b0, {16'h0000, 16'hFC0A, 16'h0000, 16'h0000});
    repeat (7) step(1'b0, {16'h0000, 16'h1C11, 16'h0000, 16'h0000});
    step(1'b0, 64'h0);

    // Reset mid-lock, then the same request is granted right away
    step(1'b0, {16'h0000, 16'h0000, 16'hFC05, 16'h0000});
    step(1'b0, {16'h0000, 16'h0000, 16'h1C11, 16'h0000});
    step(1'b1, {16'h0000, 16'h0000, 16'hFC05, 16'h0000});
    step(1'b0, {16'h0000, 16'h0000, 16'hFC05, 16'h0000});
    step(1'b0, {16'h0000, 16'h0000, 16'hFCFF, 16'h0000});
    step(1'b0, 64'h0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      v = '0;
      r = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        sel = $urandom_range(0, 9);
        if (m_locked && (i == m_owner)) begin
          if (sel < 3)       v[16*i +: 16] = 16'hFCFF;
          else if (sel == 3) v[16*i +: 16] = {12'hFC0, 4'($urandom_range(1, 15))};
          else               v[16*i +: 16] = 16'($urandom);
        end else begin
          if (sel < 4)       v[16*i +: 16] = 16'h0000;
          else if (sel < 8)  v[16*i +: 16] = {12'hFC0, 4'($urandom_range(1, 3))};
          else if (sel == 8) v[16*i +: 16] = 16'hFCFF;
          else               v[16*i +: 16] = 16'($urandom);
        end
      end
      step(r, v);
    end

    // Every prediction must have been consumed
    repeat (2) @(posedge CLK);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
